multdiv_seq: RTL
================

MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ctrl_MULT, input, 1, one-cycle start pulse for signed multiply.
REQ-004 SHALL have port ctrl_DIV, input, 1, one-cycle start pulse for signed divide.
REQ-005 SHALL have port data_operandA, input, 32, multiplicand or dividend, sampled only on the start edge.
REQ-006 SHALL have port data_operandB, input, 32, multiplier or divisor, sampled only on the start edge.
REQ-007 SHALL have port aluOP, output, 3, shared adder opcode: 3'b000 add, 3'b001 subtract; no other codes driven.
REQ-008 SHALL have port adder_A, output, 32, shared adder operand A.
REQ-009 SHALL have port adder_B, output, 32, shared adder operand B, un-inverted (adder applies inversion and carry-in for subtract).
REQ-010 SHALL have port adder_sum, input, 32, combinational sum from the shared adder, same cycle.
REQ-011 SHALL have port adder_cout, input, 1, carry-out of the shared adder, same cycle.
REQ-012 SHALL have port data_result, output, 32, registered product or quotient.
REQ-013 SHALL have port data_exception, output, 1, registered overflow or divide-by-zero flag.
REQ-014 SHALL have port data_resultRDY, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, ITER, FIX, DONE; DONE lasts one cycle, then IDLE.
REQ-016 Start edge E0: latch operands and op, clear 6-bit counter, enter ITER; ctrl_MULT wins if both starts are high.
REQ-017 A start pulse in ITER, FIX or DONE SHALL abort the current operation and restart per REQ-016; no RDY for the aborted operation.
REQ-018 ITER SHALL run 32 cycles (edges E1..E32) and use the shared adder once per cycle; after E32 enter FIX; FIX->DONE at E33.
REQ-019 data_resultRDY SHALL be high for exactly the cycle between E33 and E34; data_result/data_exception SHALL be updated at E33 and held until the next E33 or reset.
REQ-020 Multiply: radix-2 Booth on a 65-bit {ACC[32:0],Q[31:0],q-1}; {Q0,q-1}=01 drives add ACC[31:0]+M, =10 drives subtract, else add with adder_B=0; ACC bit 32 = ACC[31]^Bop[31]^adder_cout, where Bop is B inverted for subtract; then arithmetic shift right by 1.
REQ-021 Multiply: data_result = product[31:0]; data_exception=1 and data_result=0 when product[63:31] are not all equal.
REQ-022 Divide: restoring on unsigned magnitudes (internal two's-complement negate, not shared adder); each ITER shift {R,Q} left 1, subtract |B| from R; adder_cout=1 keeps difference and sets Q0=1, else R restored and Q0=0.
REQ-023 Divide: FIX negates the quotient when signA^signB=1; truncation toward zero; remainder not output.
REQ-024 Divide: B=0 or (A=32'h80000000 and B=32'hFFFFFFFF) SHALL give data_exception=1, data_result=0, same 33-cycle latency.
REQ-025 In IDLE, FIX and DONE: aluOP=3'b000, adder_A=0, adder_B=0.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, aluOP=0, adder_A=0, adder_B=0, including mid-operation; no RDY until a new start after release.

Verification
REQ-027 ctrl_MULT, A=6, B=7 -> RDY exactly 33 cycles after the start edge, result=42, exception=0.
REQ-028 ctrl_MULT, A=-3, B=5 -> result=32'hFFFFFFF1; A=B=32'h00010000 -> exception=1, result=0.
REQ-029 ctrl_DIV, A=100, B=7 -> result=14; A=-100, B=7 -> result=-14 (32'hFFFFFFF2); exception=0.
REQ-030 ctrl_DIV, A=5, B=0 -> exception=1, result=0; A=32'h80000000, B=-1 -> exception=1, result=0.
REQ-031 Start MULT 6*7, then DIV 9/3 at cycle 10 -> single RDY at 33 cycles after the second start, result=3.
REQ-032 reset_n low at cycle 15 of an operation -> all outputs 0 asynchronously; no RDY follows; next op result correct.

Source files
------------

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiplier (radix-2 Booth) and divider (restoring),
// sharing an external 32-bit adder; 33-cycle latency from the start edge.
module multdiv_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [2:0]  aluOP,
  output logic [31:0] adder_A,
  output logic [31:0] adder_B,
  input  logic [31:0] adder_sum,
  input  logic        adder_cout,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t      state, stateNext;
  logic        isDiv, negRes, divExc, qm1;
  logic [5:0]  cnt;
  logic [32:0] acc;
  logic [31:0] q, m;

  logic        start;
  logic [31:0] absA, absB;
  logic [31:0] bOp;
  logic [32:0] accNew;
  logic [63:0] product;
  logic        mulOvf;
  logic [31:0] quot;

  assign start = ctrl_MULT | ctrl_DIV;
  assign absA  = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign absB  = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  // Booth step: sign-extend the 32-bit adder result to 33 bits from the carry.
  assign bOp     = (aluOP == 3'b001) ? ~adder_B : adder_B;
  assign accNew  = {acc[31] ^ bOp[31] ^ adder_cout, adder_sum};
  assign product = {acc[31:0], q};
  assign mulOvf  = !((&product[63:31]) || !(|product[63:31]));
  assign quot    = negRes ? (~q + 32'd1) : q;
  assign data_resultRDY = (state == DONE);

  always_comb begin
    stateNext = state;
    aluOP     = 3'b000;
    adder_A   = '0;
    adder_B   = '0;
    if (start) begin
      stateNext = ITER;
    end else begin
      case (state)
        ITER:    if (cnt == 6'd31) stateNext = FIX;
        FIX:     stateNext = DONE;
        DONE:    stateNext = IDLE;
        default: stateNext = state;
      endcase
    end
    if (state == ITER) begin
      if (isDiv) begin
        aluOP   = 3'b001;
        adder_A = {acc[30:0], q[31]};
        adder_B = m;
      end else begin
        adder_A = acc[31:0];
        case ({q[0], qm1})
          2'b01:   adder_B = m;
          2'b10: begin
            aluOP   = 3'b001;
            adder_B = m;
          end
          default: adder_B = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      isDiv          <= 1'b0;
      negRes         <= 1'b0;
      divExc         <= 1'b0;
      qm1            <= 1'b0;
      acc            <= '0;
      q              <= '0;
      m              <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      state <= stateNext;
      if (start) begin
        cnt    <= '0;
        isDiv  <= ~ctrl_MULT;
        acc    <= '0;
        qm1    <= 1'b0;
        negRes <= data_operandA[31] ^ data_operandB[31];
        divExc <= (data_operandB == '0) ||
                  (data_operandA == 32'h8000_0000 && data_operandB == '1);
        if (ctrl_MULT) begin
          q <= data_operandB;
          m <= data_operandA;
        end else begin
          q <= absA;
          m <= absB;
        end
      end else if (state == ITER) begin
        cnt <= cnt + 6'd1;
        if (isDiv) begin
          // Remainder magnitude stays below 2^31, so the shifted value fits 32 bits.
          if (adder_cout) acc <= {1'b0, adder_sum};
          else            acc <= {2'b00, acc[30:0], q[31]};
          q <= {q[30:0], adder_cout};
        end else begin
          acc <= {accNew[32], accNew[32:1]};
          q   <= {accNew[0], q[31:1]};
          qm1 <= q[0];
        end
      end else if (state == FIX) begin
        if (isDiv) begin
          data_exception <= divExc;
          data_result    <= divExc ? '0 : quot;
        end else begin
          data_exception <= mulOvf;
          data_result    <= mulOvf ? '0 : product[31:0];
        end
      end
    end
  end

endmodule
